cmplx_cov_accum: RTL and testbench
==================================

# cmplx_cov_accum

Parametrised complex covariance accumulator for the sigma SoC accelerator path. Accepts N-element complex snapshot vectors over a valid/ready stream. Accumulates the upper-triangular sample covariance R[j][k] = Σ x_j·conj(x_k), k ≥ j, over a runtime-programmable number of snapshots. Results are exposed through a one-cycle-latency read port that the CPU-side bus wrapper maps into the result buffer, at 8 bytes per element.

## Interface
- N, 6: complex elements per snapshot vector (≥2); M = N(N+1)/2 result elements.
- DW, 8: bit width of each signed real/imag component.
- ACC_W, 32: signed accumulator width per real/imag result (≥ 2·DW+2).
- LEN_W, 16: width of integration-length input.

- clk_i  in  1  clock.
- arst_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  pulse; clears accumulators and starts integration (ignored while busy_o=1).
- integ_len_i  in  LEN_W  snapshot count, sampled on accepted start_i.
- s_valid_i  in  1  sample valid.
- s_ready_o  out  1  block accepts sample.
- s_data_i  in  2·DW  sample: [DW-1:0] real, [2DW-1:DW] imag, both two's complement.
- busy_o  out  1  integration in progress.
- done_o  out  1  one-cycle pulse when integration completes.
- ovf_o  out  1  sticky signed-overflow flag.
- rd_en_i  in  1  read strobe.
- rd_addr_i  in  $clog2(2M)  word address: 2e = real of element e, 2e+1 = imag.
- rd_data_o  out  ACC_W  read data.
- rd_valid_o  out  1  read data valid.

## Operation
- Element order e(j,k) = j·N − j(j−1)/2 + (k−j), for j = 0..N−1 and k = j..N−1. The order is row-major upper triangle.
- FSM states: IDLE, LOAD, MAC, FIN.
  - IDLE→LOAD on start_i with integ_len_i ≠ 0. Action: zero all 2M accumulators, clear ovf_o, snap_cnt=0.
  - IDLE→FIN on start_i with integ_len_i = 0. Action: accumulators zeroed.
  - LOAD: s_ready_o=1. Each valid&ready handshake writes vector register elem_cnt, then increments elem_cnt. After the N-th handshake, go to MAC with j=k=0.
  - MAC: one (j,k) pair per cycle.
    - re += xr_j·xr_k + xi_j·xi_k
    - im += xi_j·xr_k − xr_j·xi_k
    - Products are full-precision 2·DW bits; sums are sign-extended to ACC_W.
    - k increments; at k=N−1, j increments and k=j. After the pair (N−1,N−1), snap_cnt increments.
    - Exit to FIN if snap_cnt+1 = integ_len; otherwise exit to LOAD.
  - FIN: done_o=1 for one cycle, then go to IDLE.
- busy_o=1 in LOAD and MAC.
- Accumulation wraps modulo 2^ACC_W. ovf_o is set if any accumulate causes signed overflow. It stays set until the next accepted start_i.
- Read port:
  - rd_en_i at cycle t → rd_data_o and rd_valid_o=1 at t+1.
  - Reads are legal in any state and return current, possibly partial, values.
  - rd_addr_i ≥ 2M returns 0.
  - rd_data_o holds its value when rd_en_i=0; rd_valid_o deasserts.

## Timing
- Reset values: s_ready_o 0, busy_o 0, done_o 0, ovf_o 0, rd_data_o 0, rd_valid_o 0, all accumulators 0, FSM IDLE, all counters 0.
- Reset assertion mid-operation aborts immediately to reset values. No done_o is produced.
- start_i→first s_ready_o: 1 cycle.
- Per snapshot: at least N cycles LOAD plus exactly M cycles MAC. s_valid_i gaps stretch LOAD only.
- done_o: the cycle after the final MAC cycle. busy_o falls in the same cycle done_o rises.
- s_ready_o=0 throughout MAC, FIN and IDLE. Samples presented then are not consumed.
- A read in the same cycle as an accumulator update returns the pre-update value.
- start_i asserted in the FIN cycle is ignored; start_i is accepted from IDLE only.

## Test plan
- N=2, DW=8, integ_len=1, samples 16'h0201 (1+2i), 16'hFF03 (3−i).
  - Required after done_o: words 0..5 = 5, 0, 1, 7, 10, 0.
- Same vector, integ_len=3, with one idle cycle between valids.
  - Required: 15, 0, 3, 21, 30, 0.
  - done_o fires exactly once.
  - s_ready_o is low during each 3-cycle MAC phase.
- N=2, ACC_W=16, integ_len=1, both samples 16'h8080 (−128−128i).
  - Required: R00 real wraps to 16'h8000 and ovf_o=1.
  - A following start_i clears ovf_o to 0 and zeroes all words.
- Reset and start corner cases:
  - arst_n_i low during MAC of snapshot 2 → all outputs and reads return 0.
  - A new start_i with integ_len=1 then completes correctly.
  - start_i while busy_o=1 is ignored; result matches an undisturbed run.
- Defaults (N=6), integ_len=10, 60 samples from the 20-word test pattern streamed cyclically.
  - All 42 words must match the software reference model.
  - rd_addr_i=42 returns 0.
  - integ_len=0 gives done_o one cycle after start and all-zero results.

Source files
------------

// File: rtl/cmplx_cov_accum.sv
// cmplx_cov_accum: streaming complex covariance accumulator.
// Collects N-element complex snapshots, accumulates the upper-triangular
// R[j][k] = sum x_j * conj(x_k) over a programmable snapshot count, and
// exposes the 2M real/imag result words through a one-cycle read port.
module cmplx_cov_accum #(
  parameter int N     = 6,
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic                       start_i,
  input  logic [LEN_W-1:0]           integ_len_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic [2*DW-1:0]            s_data_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       ovf_o,
  input  logic                       rd_en_i,
  input  logic [$clog2(N*(N+1))-1:0] rd_addr_i,
  output logic [ACC_W-1:0]           rd_data_o,
  output logic                       rd_valid_o
);

  localparam int M     = N * (N + 1) / 2;
  localparam int WORDS = 2 * M;
  localparam int AW    = $clog2(WORDS);
  localparam int IW    = $clog2(N);
  localparam int EW    = $clog2(M);
  localparam int PW    = 2 * DW;
  localparam int XW    = 2 * DW + 1;
  // Wide enough that accumulator + addend can never overflow internally.
  localparam int SW    = ((ACC_W > XW) ? ACC_W : XW) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [AW:0]   WORDS_L  = (AW + 1)'(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MAC  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Full-precision signed product of two DW-bit components.
  function automatic logic signed [PW-1:0] smul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    a_ext = {{DW{a[DW-1]}}, a};
    b_ext = {{DW{b[DW-1]}}, b};
    return a_ext * b_ext;
  endfunction

  // Exact sum of accumulator and sign-extended addend at SW bits.
  function automatic logic [SW-1:0] wide_add(input logic [ACC_W-1:0] acc, input logic [XW-1:0] add);
    logic [SW-1:0] acc_ext;
    logic [SW-1:0] add_ext;
    acc_ext = {{(SW - ACC_W){acc[ACC_W-1]}}, acc};
    add_ext = {{(SW - XW){add[XW-1]}}, add};
    return acc_ext + add_ext;
  endfunction

  // Signed overflow: bits above the ACC_W sign bit disagree with it.
  function automatic logic sum_ovf(input logic [SW-1:0] sum);
    return (sum[SW-1:ACC_W-1] != {(SW - ACC_W + 1){sum[ACC_W-1]}});
  endfunction

  state_t               state_q, state_d;
  logic [IW-1:0]        elem_cnt_q, elem_cnt_d;
  logic [IW-1:0]        j_q, j_d;
  logic [IW-1:0]        k_q, k_d;
  logic [EW-1:0]        e_q, e_d;
  logic [LEN_W-1:0]     snap_cnt_q, snap_cnt_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [2*DW-1:0]      vec_q [N];
  logic [ACC_W-1:0]     acc_re_q [M];
  logic [ACC_W-1:0]     acc_im_q [M];
  logic                 ovf_q;
  logic [ACC_W-1:0]     rd_data_q;
  logic                 rd_valid_q;

  logic                 clear_s;
  logic                 load_en_s;
  logic                 mac_en_s;
  logic [DW-1:0]        xr_j_s, xi_j_s, xr_k_s, xi_k_s;
  logic signed [PW-1:0] p_rr_s, p_ii_s, p_ir_s, p_ri_s;
  logic [XW-1:0]        re_add_s, im_add_s;
  logic [SW-1:0]        re_sum_s, im_sum_s;
  logic [ACC_W-1:0]     rd_word_s;

  assign xr_j_s = vec_q[j_q][DW-1:0];
  assign xi_j_s = vec_q[j_q][2*DW-1:DW];
  assign xr_k_s = vec_q[k_q][DW-1:0];
  assign xi_k_s = vec_q[k_q][2*DW-1:DW];

  assign p_rr_s = smul(xr_j_s, xr_k_s);
  assign p_ii_s = smul(xi_j_s, xi_k_s);
  assign p_ir_s = smul(xi_j_s, xr_k_s);
  assign p_ri_s = smul(xr_j_s, xi_k_s);

  // x_j * conj(x_k): real = rr + ii, imag = ir - ri
  assign re_add_s = {p_rr_s[PW-1], p_rr_s} + {p_ii_s[PW-1], p_ii_s};
  assign im_add_s = {p_ir_s[PW-1], p_ir_s} - {p_ri_s[PW-1], p_ri_s};

  assign re_sum_s = wide_add(acc_re_q[e_q], re_add_s);
  assign im_sum_s = wide_add(acc_im_q[e_q], im_add_s);

  // Next-state and control decode for the IDLE/LOAD/MAC/FIN sequencer.
  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    j_d        = j_q;
    k_d        = k_q;
    e_d        = e_q;
    snap_cnt_d = snap_cnt_q;
    len_d      = len_q;
    clear_s    = 1'b0;
    load_en_s  = 1'b0;
    mac_en_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          clear_s    = 1'b1;
          len_d      = integ_len_i;
          snap_cnt_d = '0;
          elem_cnt_d = '0;
          j_d        = '0;
          k_d        = '0;
          e_d        = '0;
          if (integ_len_i != {LEN_W{1'b0}}) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (s_valid_i) begin
          load_en_s = 1'b1;
          if (elem_cnt_q == LAST_IDX) begin
            elem_cnt_d = '0;
            j_d        = '0;
            k_d        = '0;
            e_d        = '0;
            state_d    = ST_MAC;
          end else begin
            elem_cnt_d = elem_cnt_q + IW'(1'b1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_MAC: begin
        mac_en_s = 1'b1;
        if (k_q == LAST_IDX) begin
          if (j_q == LAST_IDX) begin
            j_d        = '0;
            k_d        = '0;
            e_d        = '0;
            snap_cnt_d = snap_cnt_q + LEN_W'(1'b1);
            if ((snap_cnt_q + LEN_W'(1'b1)) == len_q) begin
              state_d = ST_FIN;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            j_d = j_q + IW'(1'b1);
            k_d = j_q + IW'(1'b1);
            e_d = e_q + EW'(1'b1);
          end
        end else begin
          k_d = k_q + IW'(1'b1);
          e_d = e_q + EW'(1'b1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and counters.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= ST_IDLE;
      elem_cnt_q <= '0;
      j_q        <= '0;
      k_q        <= '0;
      e_q        <= '0;
      snap_cnt_q <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      e_q        <= e_d;
      snap_cnt_q <= snap_cnt_d;
      len_q      <= len_d;
    end
  end

  // Snapshot vector register, filled one element per accepted sample.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < N; i++) begin
        vec_q[i] <= '0;
      end
    end else if (load_en_s) begin
      vec_q[elem_cnt_q] <= s_data_i;
    end
  end

  // Accumulator bank and sticky overflow: cleared on accepted start, one element per MAC cycle.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < M; i++) begin
        acc_re_q[i] <= '0;
        acc_im_q[i] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (clear_s) begin
      for (int i = 0; i < M; i++) begin
        acc_re_q[i] <= '0;
        acc_im_q[i] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (mac_en_s) begin
      acc_re_q[e_q] <= re_sum_s[ACC_W-1:0];
      acc_im_q[e_q] <= im_sum_s[ACC_W-1:0];
      if (sum_ovf(re_sum_s) || sum_ovf(im_sum_s)) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Read word select; addresses past the last result word read as zero.
  always_comb begin
    rd_word_s = {ACC_W{1'b0}};
    if ({1'b0, rd_addr_i} < WORDS_L) begin
      if (rd_addr_i[0]) begin
        rd_word_s = acc_im_q[rd_addr_i[AW-1:1]];
      end else begin
        rd_word_s = acc_re_q[rd_addr_i[AW-1:1]];
      end
    end else begin
      rd_word_s = {ACC_W{1'b0}};
    end
  end

  // Read port register: data captured on strobe and held otherwise.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= rd_word_s;
      end
    end
  end

  assign s_ready_o  = (state_q == ST_LOAD);
  assign busy_o     = (state_q == ST_LOAD) || (state_q == ST_MAC);
  assign done_o     = (state_q == ST_FIN);
  assign ovf_o      = ovf_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_cmplx_cov_accum.sv
// Directed bench for cmplx_cov_accum: N=2/ACC_W=16 instance for the small
// hand-computed cases and overflow, default N=6 instance for the long run.
module tb_cmplx_cov_accum;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int a_done_cnt = 0;

  typedef int w6_t [6];

  // Instance A: N=2, ACC_W=16
  logic        a_start, a_valid, a_ready, a_busy, a_done, a_ovf, a_rd_en, a_rd_valid;
  logic [15:0] a_len, a_data, a_rd_data;
  logic [2:0]  a_rd_addr;

  // Instance B: defaults (N=6, ACC_W=32)
  logic        b_start, b_valid, b_ready, b_busy, b_done, b_ovf, b_rd_en, b_rd_valid;
  logic [15:0] b_len, b_data;
  logic [31:0] b_rd_data;
  logic [5:0]  b_rd_addr;

  cmplx_cov_accum #(.N(2), .DW(8), .ACC_W(16), .LEN_W(16)) u_a (
    .clk_i(clk), .arst_n_i(arst_n), .start_i(a_start), .integ_len_i(a_len),
    .s_valid_i(a_valid), .s_ready_o(a_ready), .s_data_i(a_data),
    .busy_o(a_busy), .done_o(a_done), .ovf_o(a_ovf),
    .rd_en_i(a_rd_en), .rd_addr_i(a_rd_addr), .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid)
  );

  cmplx_cov_accum u_b (
    .clk_i(clk), .arst_n_i(arst_n), .start_i(b_start), .integ_len_i(b_len),
    .s_valid_i(b_valid), .s_ready_o(b_ready), .s_data_i(b_data),
    .busy_o(b_busy), .done_o(b_done), .ovf_o(b_ovf),
    .rd_en_i(b_rd_en), .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid)
  );

  always @(posedge clk) if (a_done) a_done_cnt <= a_done_cnt + 1;

  logic [15:0] pat [20] = '{
    16'h0201, 16'hFF03, 16'h7F80, 16'h8001, 16'h05FB, 16'hF00F, 16'h1234, 16'hEDCB, 16'h0000, 16'h7F7F,
    16'h8080, 16'h01FF, 16'hC040, 16'h3FC1, 16'h0A0A, 16'hF6F6, 16'h6C93, 16'h9A65, 16'h0080, 16'h8000
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cre(input logic [15:0] d);
    byte b;
    b = d[7:0];
    return int'(b);
  endfunction

  function automatic int cim(input logic [15:0] d);
    byte b;
    b = d[15:8];
    return int'(b);
  endfunction

  // ---- instance A helpers (all called at a negedge) ----
  task automatic a_start_pulse(input logic [15:0] len);
    a_start = 1'b1; a_len = len;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic a_send(input logic [15:0] d);
    int t = 0;
    a_valid = 1'b1; a_data = d;
    while (!a_ready && t < 100) begin @(negedge clk); t++; end
    check("a_send_ready", {31'd0, a_ready}, 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic a_wait_done(output int cyc);
    cyc = 0;
    while (!a_done && cyc < 200) begin @(negedge clk); cyc++; end
    check("a_done_seen", {31'd0, a_done}, 32'd1);
  endtask

  task automatic a_check6(input string tag, input w6_t exp);
    for (int i = 0; i < 6; i++) begin
      a_rd_en = 1'b1; a_rd_addr = 3'(i);
      @(negedge clk);
      a_rd_en = 1'b0;
      check($sformatf("%s_valid%0d", tag, i), {31'd0, a_rd_valid}, 32'd1);
      check($sformatf("%s_word%0d", tag, i), {16'd0, a_rd_data}, exp[i]);
    end
  endtask

  // ---- instance B helpers ----
  task automatic b_start_pulse(input logic [15:0] len);
    b_start = 1'b1; b_len = len;
    @(negedge clk);
    b_start = 1'b0;
  endtask

  task automatic b_send(input logic [15:0] d);
    int t = 0;
    b_valid = 1'b1; b_data = d;
    while (!b_ready && t < 100) begin @(negedge clk); t++; end
    check("b_send_ready", {31'd0, b_ready}, 32'd1);
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic b_read(input logic [5:0] addr, output logic [31:0] d);
    b_rd_en = 1'b1; b_rd_addr = addr;
    @(negedge clk);
    b_rd_en = 1'b0;
    d = b_rd_data;
  endtask

  initial begin
    int cyc;
    int d0;
    int e;
    int exp_re [21];
    int exp_im [21];
    logic [15:0] xj, xk;
    logic [31:0] rd;

    a_start = 1'b0; a_len = 16'd0; a_valid = 1'b0; a_data = 16'd0; a_rd_en = 1'b0; a_rd_addr = 3'd0;
    b_start = 1'b0; b_len = 16'd0; b_valid = 1'b0; b_data = 16'd0; b_rd_en = 1'b0; b_rd_addr = 6'd0;
    arst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_ready", {31'd0, a_ready}, 32'd0);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_done", {31'd0, a_done}, 32'd0);
    check("rst_ovf", {31'd0, a_ovf}, 32'd0);
    check("rst_rd_valid", {31'd0, a_rd_valid}, 32'd0);
    check("rst_rd_data", {16'd0, a_rd_data}, 32'd0);
    check("rst_b_busy", {31'd0, b_busy}, 32'd0);
    arst_n = 1'b1;
    @(negedge clk);

    // T1: single snapshot (1+2i, 3-i)
    a_start_pulse(16'd1);
    check("t1_ready_after_start", {31'd0, a_ready}, 32'd1);
    check("t1_busy_after_start", {31'd0, a_busy}, 32'd1);
    a_send(16'h0201);
    a_send(16'hFF03);
    a_wait_done(cyc);
    check("t1_done_latency", cyc, 32'd3);
    check("t1_busy_at_done", {31'd0, a_busy}, 32'd0);
    @(negedge clk);
    a_check6("t1", '{5, 0, 1, 7, 10, 0});

    // T2: three snapshots with a one-cycle gap between valids
    d0 = a_done_cnt;
    a_start_pulse(16'd3);
    for (int s = 0; s < 3; s++) begin
      a_send(16'h0201);
      @(negedge clk);
      a_send(16'hFF03);
      for (int c = 0; c < 3; c++) begin
        check("t2_mac_ready_low", {31'd0, a_ready}, 32'd0);
        check("t2_mac_busy", {31'd0, a_busy}, 32'd1);
        @(negedge clk);
      end
      if (s == 2) begin
        check("t2_done", {31'd0, a_done}, 32'd1);
        check("t2_busy_at_done", {31'd0, a_busy}, 32'd0);
      end else begin
        check("t2_reload_ready", {31'd0, a_ready}, 32'd1);
      end
    end
    @(negedge clk);
    check("t2_done_pulse", {31'd0, a_done}, 32'd0);
    check("t2_done_count", a_done_cnt - d0, 32'd1);
    a_check6("t2", '{15, 0, 3, 21, 30, 0});

    // T3: overflow at ACC_W=16, then a new start clears it
    a_start_pulse(16'd1);
    a_send(16'h8080);
    a_send(16'h8080);
    a_wait_done(cyc);
    @(negedge clk);
    check("t3_ovf_set", {31'd0, a_ovf}, 32'd1);
    a_check6("t3", '{32768, 0, 32768, 0, 32768, 0});
    a_start_pulse(16'd1);
    check("t3_ovf_cleared", {31'd0, a_ovf}, 32'd0);
    a_check6("t3_clr", '{0, 0, 0, 0, 0, 0});
    a_send(16'h0201);
    a_send(16'hFF03);
    a_wait_done(cyc);
    @(negedge clk);
    check("t3_ovf_after", {31'd0, a_ovf}, 32'd0);
    a_check6("t3_after", '{5, 0, 1, 7, 10, 0});

    // T4: reset during MAC of snapshot 2
    d0 = a_done_cnt;
    a_start_pulse(16'd3);
    a_send(16'h0201);
    a_send(16'hFF03);
    repeat (3) @(negedge clk);
    a_send(16'h0201);
    a_send(16'hFF03);
    check("t4_in_mac", {31'd0, a_busy}, 32'd1);
    arst_n = 1'b0;
    #1;
    check("t4_rst_busy", {31'd0, a_busy}, 32'd0);
    check("t4_rst_ready", {31'd0, a_ready}, 32'd0);
    check("t4_rst_done", {31'd0, a_done}, 32'd0);
    check("t4_rst_ovf", {31'd0, a_ovf}, 32'd0);
    check("t4_rst_rd_data", {16'd0, a_rd_data}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    a_check6("t4", '{0, 0, 0, 0, 0, 0});
    check("t4_no_done", a_done_cnt - d0, 32'd0);

    // T5: start while busy ignored; start during FIN ignored
    a_start_pulse(16'd1);
    a_send(16'h0201);
    a_start_pulse(16'd5);
    a_send(16'hFF03);
    a_wait_done(cyc);
    check("t5_done_latency", cyc, 32'd3);
    a_start_pulse(16'd1);
    check("t5_fin_start_busy", {31'd0, a_busy}, 32'd0);
    check("t5_fin_start_ready", {31'd0, a_ready}, 32'd0);
    @(negedge clk);
    check("t5_still_idle", {31'd0, a_busy}, 32'd0);
    a_check6("t5", '{5, 0, 1, 7, 10, 0});

    // T6: N=6, 10 snapshots from the cyclic 20-word pattern
    for (int i = 0; i < 21; i++) begin exp_re[i] = 0; exp_im[i] = 0; end
    for (int s = 0; s < 10; s++) begin
      for (int j = 0; j < 6; j++) begin
        for (int k = j; k < 6; k++) begin
          xj = pat[(s * 6 + j) % 20];
          xk = pat[(s * 6 + k) % 20];
          e = j * 6 - (j * (j - 1)) / 2 + (k - j);
          exp_re[e] += cre(xj) * cre(xk) + cim(xj) * cim(xk);
          exp_im[e] += cim(xj) * cre(xk) - cre(xj) * cim(xk);
        end
      end
    end
    b_start_pulse(16'd10);
    for (int i = 0; i < 60; i++) b_send(pat[i % 20]);
    cyc = 0;
    while (!b_done && cyc < 2000) begin @(negedge clk); cyc++; end
    check("t6_done_seen", {31'd0, b_done}, 32'd1);
    @(negedge clk);
    check("t6_ovf", {31'd0, b_ovf}, 32'd0);
    for (int w = 0; w < 42; w++) begin
      b_read(6'(w), rd);
      check($sformatf("t6_word%0d", w), rd, (w % 2 == 0) ? exp_re[w / 2] : exp_im[w / 2]);
    end
    b_read(6'd42, rd);
    check("t6_addr42_zero", rd, 32'd0);
    check("t6_addr42_valid", {31'd0, b_rd_valid}, 32'd1);

    // T7: integ_len = 0
    b_start_pulse(16'd0);
    check("t7_done", {31'd0, b_done}, 32'd1);
    check("t7_busy", {31'd0, b_busy}, 32'd0);
    check("t7_ready", {31'd0, b_ready}, 32'd0);
    @(negedge clk);
    check("t7_done_pulse", {31'd0, b_done}, 32'd0);
    for (int w = 0; w < 42; w++) begin
      b_read(6'(w), rd);
      check($sformatf("t7_word%0d", w), rd, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
